// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering one MEM-stage request
// at a time through an IDLE -> CHECK -> ACCESS -> RESP sequence.
// Optional feature: define DMEM_PARITY_EN to keep one even-parity bit per byte
// lane and report a parity mismatch on reads through mem_err.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        soc_clk,
  input  logic        DMEM_reset,
  input  logic        memfetch_start,
  input  logic [31:0] addr,
  input  logic [3:0]  bits_to_access,
  input  logic        read_or_write,
  input  logic [31:0] wdata,
  input  logic        MEM_stall,
  output logic [31:0] MEM_data,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, CHECK, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic             err_q, err_d;
  logic [31:0]      data_d;
  logic             done_d, busy_d, err_out_d;
  logic             wr_en_c;
  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      off_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0]      word_c, lane_mask_c;
  logic             range_err_c, align_err_c, parity_err_c;
  logic             unused_off;

  // Word index relative to the window base; byte offset and high bits unused.
  assign off_c      = req_q.addr - BASE_ADDR;
  assign idx_c      = off_c[IDX_W+1:2];
  assign unused_off = ^{off_c[31:IDX_W+2], off_c[1:0]};
  assign word_c     = mem_q[idx_c];

  assign lane_mask_c = {{8{req_q.mask[3]}}, {8{req_q.mask[2]}},
                        {8{req_q.mask[1]}}, {8{req_q.mask[0]}}};

  // Window check in 33 bits so the upper bound cannot wrap.
  assign range_err_c = ({1'b0, req_q.addr} < ADDR_LO) || ({1'b0, req_q.addr} >= ADDR_HI);

  // Only naturally aligned byte, halfword and word lane patterns are legal.
  always_comb begin
    align_err_c = 1'b1;
    case ({req_q.mask, req_q.addr[1:0]})
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: align_err_c = 1'b0;
      default:                            align_err_c = 1'b1;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_q [DEPTH_WORDS];
  logic [3:0] par_calc_c;

  // Recompute even parity of each stored lane for the read in ACCESS.
  always_comb begin
    par_calc_c = '0;
    for (int i = 0; i < 4; i++) par_calc_c[i] = ^word_c[8*i +: 8];
  end

  assign parity_err_c = ~req_q.wr & (|((par_calc_c ^ par_q[idx_c]) & req_q.mask));

  // Parity bits follow the lane data they protect.
  always_ff @(posedge soc_clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_q.mask[i]) par_q[idx_c][i] <= ^req_q.wdata[8*i +: 8];
      end
    end
  end
`else
  assign parity_err_c = 1'b0;
`endif

  // Lane-masked array write; the array is deliberately outside reset.
  always_ff @(posedge soc_clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_q.mask[i]) mem_q[idx_c][8*i +: 8] <= req_q.wdata[8*i +: 8];
      end
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge soc_clk) begin
    if (DMEM_reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      err_q    <= 1'b0;
      MEM_data <= '0;
      mem_done <= 1'b0;
      mem_busy <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      err_q    <= err_d;
      MEM_data <= data_d;
      mem_done <= done_d;
      mem_busy <= busy_d;
      mem_err  <= err_out_d;
    end
  end

  // Next state and next output values; outputs are zero outside RESP.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    err_d     = err_q;
    data_d    = '0;
    done_d    = 1'b0;
    err_out_d = 1'b0;
    wr_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memfetch_start) begin
          req_d   = '{addr: addr, mask: bits_to_access, wr: read_or_write, wdata: wdata};
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_d   = range_err_c | align_err_c;
        state_d = ACCESS;
      end
      ACCESS: begin
        wr_en_c   = ~err_q & req_q.wr;
        done_d    = 1'b1;
        err_out_d = err_q | (~err_q & parity_err_c);
        if (!err_q && !req_q.wr) data_d = word_c & lane_mask_c;
        state_d   = RESP;
      end
      RESP: begin
        if (MEM_stall) begin
          done_d    = 1'b1;
          err_out_d = mem_err;
          data_d    = MEM_data;
        end else begin
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver pushes model-predicted
// responses, a monitor pops and checks them whenever mem_done rises.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        soc_clk = 1'b0;
  logic        DMEM_reset = 1'b1;
  logic        memfetch_start = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  bits_to_access = '0;
  logic        read_or_write = 1'b0;
  logic [31:0] wdata = '0;
  logic        MEM_stall = 1'b0;
  logic [31:0] MEM_data;
  logic        mem_done, mem_busy, mem_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .soc_clk(soc_clk), .DMEM_reset(DMEM_reset), .memfetch_start(memfetch_start),
    .addr(addr), .bits_to_access(bits_to_access), .read_or_write(read_or_write),
    .wdata(wdata), .MEM_stall(MEM_stall), .MEM_data(MEM_data),
    .mem_done(mem_done), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 soc_clk = ~soc_clk;

  int cyc = 0;
  always @(posedge soc_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          exp_cyc;
    int          n_high;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Legal = 1, 2 or 4 contiguous lanes starting at addr[1:0], size-aligned.
  function automatic bit is_legal(input logic [3:0] m, input logic [1:0] lo);
    int n;
    logic [7:0] pat;
    n = $countones(m);
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if ((int'(lo) % n) != 0) return 1'b0;
    pat = 8'(((1 << n) - 1) << lo);
    return pat == {4'b0000, m};
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(DEPTH) * 4);
  endfunction

  // Issue one request at a negedge; returns at the first negedge back in IDLE.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] wd, input int stall, input bit extra,
                       input bit par_err = 1'b0);
    int   c;
    int   w;
    exp_t e;
    c = cyc;
    e.exp_cyc = c + 3;
    e.n_high  = 1 + stall;
    if (!is_legal(m, a[1:0]) || !in_range(a)) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      w = int'((a - BASE) >> 2);
      e.err = par_err;
      e.data = '0;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          if (wr) mdl[w][8*i +: 8] = wd[8*i +: 8];
          else    e.data[8*i +: 8] = mdl[w][8*i +: 8];
        end
      end
    end
    sb.push_back(e);
    memfetch_start = 1'b1;
    addr = a; bits_to_access = m; read_or_write = wr; wdata = wd;
    @(negedge soc_clk);
    chk("busy_in_check", 32'(mem_busy), 32'd1);
    memfetch_start = extra;
    if (extra) begin
      addr = a ^ 32'h4; read_or_write = ~wr; wdata = ~wd; bits_to_access = 4'hF;
    end
    if (stall > 0) MEM_stall = 1'b1;
    @(negedge soc_clk);
    memfetch_start = 1'b0;
    repeat (1 + stall) @(negedge soc_clk);
    MEM_stall = 1'b0;
    @(negedge soc_clk);
  endtask

  // Monitor: check each response against the scoreboard head.
  exp_t cur;
  bit   active = 1'b0;
  bit   prev_done = 1'b0;
  int   high = 0;
  always @(negedge soc_clk) begin
    if (!DMEM_reset) begin
      if (mem_done === 1'b1) begin
        if (!prev_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
            active = 1'b0;
          end else begin
            cur = sb.pop_front();
            active = 1'b1;
            high = 1;
            chk("latency_cycle", 32'(cyc), 32'(cur.exp_cyc));
            chk("resp_data", MEM_data, cur.data);
            chk("resp_err", 32'(mem_err), 32'(cur.err));
          end
        end else if (active) begin
          high++;
          chk("held_data", MEM_data, cur.data);
          chk("held_err", 32'(mem_err), 32'(cur.err));
        end
      end else begin
        if (prev_done && active) begin
          chk("done_high_cycles", 32'(high), 32'(cur.n_high));
          active = 1'b0;
        end
        if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
          chk("response_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
        chk("idle_data_zero", MEM_data, 32'h0);
      end
      prev_done = (mem_done === 1'b1);
    end else begin
      prev_done = 1'b0;
      active = 1'b0;
    end
  end

  logic [3:0] mlist [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  logic [1:0] llist [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    logic [1:0]  lo;
    int          k;
    repeat (3) @(negedge soc_clk);
    chk("reset_data", MEM_data, 32'h0);
    chk("reset_done", 32'(mem_done), 32'd0);
    chk("reset_busy", 32'(mem_busy), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    DMEM_reset = 1'b0;
    @(negedge soc_clk);

    for (int w = 0; w < 8; w++) issue(1'b1, BASE + 32'(w * 4), 4'hF, $urandom, 0, 1'b0);

    // Word write/read, then byte write and halfword read.
    issue(1'b1, 32'h1000, 4'b1111, 32'hDEADBEEF, 0, 1'b0);
    issue(1'b0, 32'h1000, 4'b1111, 32'h0, 0, 1'b0);
    issue(1'b1, 32'h1002, 4'b0100, 32'h00AA0000, 0, 1'b0);
    issue(1'b0, 32'h1002, 4'b1100, 32'h0, 0, 1'b0);

    // Misaligned read, out-of-range write, then word 0 must be unchanged.
    issue(1'b0, 32'h1001, 4'b0011, 32'h0, 0, 1'b0);
    issue(1'b1, 32'h1400, 4'b1111, 32'hFFFFFFFF, 0, 1'b0);
    issue(1'b1, 32'h0FFC, 4'b1111, 32'hFFFFFFFF, 0, 1'b0);
    issue(1'b1, 32'h1000, 4'b0000, 32'hFFFFFFFF, 0, 1'b0);
    issue(1'b0, 32'h13FC, 4'b1000, 32'h0, 0, 1'b0);
    issue(1'b0, 32'h1000, 4'b1111, 32'h0, 0, 1'b0);

    // Stall for 5 cycles in RESP with a stray start during CHECK.
    issue(1'b0, 32'h1000, 4'b1111, 32'h0, 5, 1'b1);

    // Reset while a write sits in CHECK: nothing commits.
    memfetch_start = 1'b1; addr = 32'h1004; bits_to_access = 4'hF;
    read_or_write = 1'b1; wdata = 32'h12345678;
    @(negedge soc_clk);
    memfetch_start = 1'b0;
    DMEM_reset = 1'b1;
    @(negedge soc_clk);
    chk("rst_mid_data", MEM_data, 32'h0);
    chk("rst_mid_done", 32'(mem_done), 32'd0);
    chk("rst_mid_busy", 32'(mem_busy), 32'd0);
    chk("rst_mid_err", 32'(mem_err), 32'd0);
    DMEM_reset = 1'b0;
    @(negedge soc_clk);
    issue(1'b0, 32'h1004, 4'b1111, 32'h0, 0, 1'b0);

`ifdef DMEM_PARITY_EN
    dut.mem_q[0] = dut.mem_q[0] ^ 32'h1;
    mdl[0] = mdl[0] ^ 32'h1;
    issue(1'b0, 32'h1000, 4'b0001, 32'h0, 0, 1'b0, 1'b1);
    issue(1'b1, 32'h1000, 4'b1111, $urandom, 0, 1'b0);
`endif

    // Randomised traffic over an initialised window plus illegal requests.
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 7);
      if (k < 7) begin
        m = mlist[k]; lo = llist[k];
      end else begin
        m = 4'($urandom); lo = 2'($urandom);
      end
      a = BASE + 32'($urandom_range(0, 7) * 4) + 32'(lo);
      k = $urandom_range(0, 9);
      if (k == 0) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
      else if (k == 1) a = BASE - 32'($urandom_range(1, 16));
      issue(1'($urandom), a, m, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    repeat (6) @(negedge soc_clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the internal data array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning the byte address of word 0; BASE_ADDR SHALL be word-aligned.
REQ-003 SHALL have port soc_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port DMEM_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port memfetch_start  input  1  request strobe from the MEM stage.
REQ-006 SHALL have port addr  input  32  request byte address.
REQ-007 SHALL have port bits_to_access  input  4  byte-lane enable mask, bit n = byte lane n.
REQ-008 SHALL have port read_or_write  input  1  0 = read, 1 = write.
REQ-009 SHALL have port wdata  input  32  write data, lane-aligned.
REQ-010 SHALL have port MEM_stall  input  1  hold request from the MEM stage.
REQ-011 SHALL have port MEM_data  output  32  read response data.
REQ-012 SHALL have port mem_done  output  1  response valid.
REQ-013 SHALL have port mem_busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port mem_err  output  1  request rejected; qualified by mem_done.

Function
REQ-015 SHALL implement a four-state FSM IDLE -> CHECK -> ACCESS -> RESP -> IDLE, with one state per cycle except when held as described in REQ-022.
REQ-016 SHALL, in IDLE with memfetch_start=1, latch addr, bits_to_access, read_or_write and wdata, and go to CHECK on the next cycle; memfetch_start SHALL be ignored in every other state.
REQ-017 SHALL, in CHECK, flag a request as an error if the address is out of range, i.e. addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS, with 33-bit compare and no wrap.
REQ-018 SHALL, in CHECK, accept only these (mask, addr[1:0]) pairs and flag all others as errors, including mask 4'b0000:
  - 0001/00, 0010/01, 0100/10, 1000/11
  - 0011/00, 1100/10
  - 1111/00
REQ-019 SHALL compute the word index as (addr - BASE_ADDR) >> 2.
REQ-020 SHALL, in ACCESS for a non-error write, update only the enabled byte lanes of the array word; error requests SHALL never modify the array.
REQ-021 SHALL, in ACCESS for a non-error read, capture the array word with disabled lanes forced to zero, keeping lanes in place with no shifting.
REQ-022 SHALL, in RESP, assert mem_done=1:
  - For reads, MEM_data SHALL be the captured word.
  - For writes or errors, MEM_data SHALL be 0.
  - mem_err SHALL be 1 for error requests.
  - While MEM_stall=1, the FSM SHALL remain in RESP with all outputs held.
  - The FSM SHALL leave RESP on the first cycle with MEM_stall=0.
REQ-023 SHALL deassert mem_done, mem_err and MEM_data (to 0) in every state other than RESP.
REQ-024 SHALL give a latency of exactly 3 cycles from the sampling edge of memfetch_start to the first cycle of mem_done=1 when unstalled; back-to-back requests SHALL be accepted every 4 cycles.
REQ-025 SHALL treat a write followed by a read of the same word as returning the newly written data, since the write commits in ACCESS before the next request begins.

Reset
REQ-026 SHALL, on DMEM_reset=1 at a rising edge, force state to IDLE and drive MEM_data=0, mem_done=0, mem_busy=0 and mem_err=0 from the next cycle.
REQ-027 SHALL give reset priority over memfetch_start and MEM_stall.
REQ-028 SHALL abort any in-flight request on reset:
  - A reset asserted in IDLE or CHECK SHALL commit no write.
  - A write already committed in ACCESS before the reset edge SHALL remain committed.
REQ-029 SHALL leave array contents unchanged on reset.

Configuration
REQ-030 SHALL, with macro DMEM_PARITY_EN defined:
  - store one even-parity bit per byte lane, written with the lane data;
  - recompute parity on read in ACCESS;
  - on any mismatch in an enabled lane, set mem_err=1 in RESP with MEM_data still carrying the read data.
REQ-031 SHALL, with DMEM_PARITY_EN undefined, contain no parity storage or logic, and mem_err SHALL reflect only REQ-017 and REQ-018 errors.

Verification
REQ-032 SHALL cover a word write then read:
  - Stimulus: write addr=0x1000, mask=1111, wdata=0xDEADBEEF; then read the same address with mask 1111.
  - Required response: mem_done exactly 3 cycles after each start, and the read returns MEM_data=0xDEADBEEF with mem_err=0.
REQ-033 SHALL cover a byte write then halfword read:
  - Stimulus: write addr=0x1002, mask=0100, wdata=0x00AA0000 over the word from REQ-032; then read addr=0x1002, mask=1100.
  - Required response: MEM_data=0xDEAA0000.
REQ-034 SHALL cover error requests:
  - Stimulus: read addr=0x1001 with mask=0011; separately, write addr=0x1400, one past the end with DEPTH_WORDS=256.
  - Required response: mem_done=1, mem_err=1 and MEM_data=0 for each, and a subsequent read of word 0 is unchanged.
REQ-035 SHALL cover stall and ignored start:
  - Stimulus: hold MEM_stall=1 for 5 cycles during RESP, and pulse memfetch_start during CHECK.
  - Required response: mem_done stays high for 5 extra cycles with data held, and the extra start is not serviced.
REQ-036 SHALL cover reset mid-write:
  - Stimulus: write 0x12345678 to 0x1004 and assert DMEM_reset in CHECK.
  - Required response: all outputs are 0 the next cycle, and a later read of 0x1004 returns the prior contents.
REQ-037 SHALL cover parity, with DMEM_PARITY_EN defined:
  - Stimulus: force a flipped bit in the stored byte 0 of word 0, then read it with mask 0001.
  - Required response: mem_err=1 with mem_done.
